period_scheduler: RTL
=====================

Name: period_scheduler

Overview:
Consumer of the minute counter and day-end pulse from the school-day timer. Decodes the running minute count into class periods and breaks. Emits per-period start/end pulses, and issues a req/ack seat-release request to the seating table at the end of every class. Sits between the timer and the seat-allocation logic.

Parameters:
TIME_W, 11, width of the minute count input
NUM_PERIODS, 7, classes per day (1..8)
FIRST_START, 60, minute value at which class 0 starts
CLASS_LEN, 50, class length in minutes (>=1)
BREAK_LEN, 10, break length in minutes (>=1)
Elaboration check: FIRST_START + NUM_PERIODS*(CLASS_LEN+BREAK_LEN) < 2**TIME_W.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
time_in  input  TIME_W  current minute count from timer
day_end  input  1  one-cycle day-end pulse from timer (timer count returns to 0)
release_ack  input  1  seat table accepted current release request
period  output  3  index of current/last class, 0..NUM_PERIODS-1
in_class  output  1  high while state==CLASS
period_start  output  1  one-cycle pulse, class begins
period_end  output  1  one-cycle pulse, class ends
release_req  output  1  seat-release request, held until acked
release_period  output  3  class whose seats are released, stable while release_req=1
day_done  output  1  high in DONE state
release_ovf  output  1  sticky: release needed while previous still pending

Behaviour:
- One clock, rst synchronous active-high. All outputs registered; reset value 0 for every output. Internal state PRE, boundary=FIRST_START, pend cleared.
- States: PRE (before class 0), CLASS, BREAK, DONE. Internal registers: boundary[TIME_W-1:0] and period count.
- Boundary hit = (time_in == boundary), sampled at posedge. Outputs reflect the hit one cycle later (latency 1).
- PRE + hit -> CLASS. period=0, period_start=1, boundary += CLASS_LEN.
- CLASS + hit:
  - If period == NUM_PERIODS-1: -> DONE, day_done=1.
  - Else: -> BREAK, boundary += BREAK_LEN.
  - Both cases: period_end=1, release request issued for the current period.
- BREAK + hit -> CLASS. period += 1, period_start=1, boundary += CLASS_LEN.
- DONE: ignores time_in. Holds until day_end.
- day_end has priority over a same-cycle boundary hit. Next state PRE, boundary=FIRST_START, period=0, day_done=0.
  - If day_end arrives in CLASS: also period_end=1 and a release request for the current period.
- period_start/period_end are high for exactly one cycle. in_class tracks state.
- Release handshake:
  - Issuing a request sets release_req=1 and loads release_period.
  - release_req stays high with release_period unchanged until release_ack is sampled high. release_req is 0 the cycle after ack.
  - release_ack with release_req=0 is ignored.
  - Ack and a new request in the same cycle: release_req stays 1 and release_period loads the new value (back-to-back).
  - New request while one is pending and no ack that cycle: release_ovf sets (sticky until rst). The pending request is kept and the new one dropped.
- rst mid-operation: drops release_req immediately (next cycle 0), clears release_ovf, returns to PRE.
- Arithmetic: boundary additions are TIME_W-bit unsigned. The elaboration check guarantees no wrap.
- time_in is not required to be monotonic. Only exact equality triggers transitions; skipped values mean no transition.

Test Plan:
(Bench params: FIRST_START=5, CLASS_LEN=3, BREAK_LEN=2, NUM_PERIODS=2; release_ack tied 1 unless noted.)
1. Full day: time_in counts 0..20 one per cycle.
   - Cycle after time_in=5: period_start=1, in_class=1, period=0.
   - After 8: period_end=1, release_req=1, release_period=0, in_class=0.
   - After 10: period_start=1, period=1.
   - After 13: period_end=1, release_period=1, day_done=1.
   - Later values: no pulses.
2. day_end during DONE: day_done falls next cycle. Replaying time_in from 0 gives period_start again after 5 with period=0.
3. day_end during CLASS (time_in=6, period 0): next cycle period_end=1, release_req=1, release_period=0, state PRE, in_class=0.
4. Handshake stall: release_ack=0 for 4 cycles after the first period_end. release_req stays 1 and release_period=0 throughout. Ack on cycle 5 -> release_req=0 next cycle.
5. Overflow: hold release_ack=0 through both period ends. release_ovf=1 after the second period_end, release_period stays 0. Only rst clears release_ovf.
6. rst asserted while in BREAK with release_req pending: next cycle all outputs 0. A subsequent time_in=5 restarts at period 0.

Source files
------------

// File: rtl/period_scheduler.sv
// rtl/period_scheduler.sv - decodes the school-day minute count into class periods and breaks
// Emits period start/end pulses and a held req/ack seat-release request per finished class.
module period_scheduler #(
  parameter int TIME_W      = 11,
  parameter int NUM_PERIODS = 7,
  parameter int FIRST_START = 60,
  parameter int CLASS_LEN   = 50,
  parameter int BREAK_LEN   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_in,
  input  logic              day_end,
  input  logic              release_ack,
  output logic [2:0]        period,
  output logic              in_class,
  output logic              period_start,
  output logic              period_end,
  output logic              release_req,
  output logic [2:0]        release_period,
  output logic              day_done,
  output logic              release_ovf
);

  if ((FIRST_START + NUM_PERIODS * (CLASS_LEN + BREAK_LEN) >= 2 ** TIME_W) ||
      (NUM_PERIODS < 1) || (NUM_PERIODS > 8) || (CLASS_LEN < 1) || (BREAK_LEN < 1))
  begin : g_param_check
    $error("period_scheduler: day schedule does not fit the minute counter");
  end

  localparam logic [TIME_W-1:0] FIRST_W = TIME_W'(FIRST_START);
  localparam logic [TIME_W-1:0] CLASS_W = TIME_W'(CLASS_LEN);
  localparam logic [TIME_W-1:0] BREAK_W = TIME_W'(BREAK_LEN);
  localparam logic [2:0]        LAST_P  = 3'(NUM_PERIODS - 1);

  typedef enum logic [1:0] {
    S_PRE,
    S_CLASS,
    S_BREAK,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] boundary_q, boundary_d;
  logic [2:0]        period_q, period_d;
  logic              in_class_q, in_class_d;
  logic              period_start_q, period_start_d;
  logic              period_end_q, period_end_d;
  logic              release_req_q, release_req_d;
  logic [2:0]        release_period_q, release_period_d;
  logic              day_done_q, day_done_d;
  logic              release_ovf_q, release_ovf_d;
  logic              hit;
  logic              issue;

  always_comb begin
    state_d          = state_q;
    boundary_d       = boundary_q;
    period_d         = period_q;
    period_start_d   = 1'b0;
    period_end_d     = 1'b0;
    issue            = 1'b0;
    hit              = (time_in == boundary_q);
    release_req_d    = release_req_q;
    release_period_d = release_period_q;
    release_ovf_d    = release_ovf_q;

    // day_end wins over a boundary hit in the same cycle
    if (day_end) begin
      if (state_q == S_CLASS) begin
        period_end_d = 1'b1;
        issue        = 1'b1;
      end
      state_d    = S_PRE;
      boundary_d = FIRST_W;
      period_d   = 3'd0;
    end else begin
      case (state_q)
        S_PRE: begin
          if (hit) begin
            state_d        = S_CLASS;
            period_d       = 3'd0;
            period_start_d = 1'b1;
            boundary_d     = boundary_q + CLASS_W;
          end
        end
        S_CLASS: begin
          if (hit) begin
            period_end_d = 1'b1;
            issue        = 1'b1;
            if (period_q == LAST_P) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_BREAK;
              boundary_d = boundary_q + BREAK_W;
            end
          end
        end
        S_BREAK: begin
          if (hit) begin
            state_d        = S_CLASS;
            period_d       = period_q + 3'd1;
            period_start_d = 1'b1;
            boundary_d     = boundary_q + CLASS_W;
          end
        end
        S_DONE: begin
        end
        default: state_d = S_PRE;
      endcase
    end

    // A still-pending request is never overwritten; a colliding new one is dropped and flagged.
    if (release_req_q && !release_ack) begin
      if (issue) begin
        release_ovf_d = 1'b1;
      end
    end else begin
      release_req_d = issue;
      if (issue) begin
        release_period_d = period_q;
      end
    end

    in_class_d = (state_d == S_CLASS);
    day_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_PRE;
      boundary_q       <= FIRST_W;
      period_q         <= 3'd0;
      in_class_q       <= 1'b0;
      period_start_q   <= 1'b0;
      period_end_q     <= 1'b0;
      release_req_q    <= 1'b0;
      release_period_q <= 3'd0;
      day_done_q       <= 1'b0;
      release_ovf_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      boundary_q       <= boundary_d;
      period_q         <= period_d;
      in_class_q       <= in_class_d;
      period_start_q   <= period_start_d;
      period_end_q     <= period_end_d;
      release_req_q    <= release_req_d;
      release_period_q <= release_period_d;
      day_done_q       <= day_done_d;
      release_ovf_q    <= release_ovf_d;
    end
  end

  assign period         = period_q;
  assign in_class       = in_class_q;
  assign period_start   = period_start_q;
  assign period_end     = period_end_q;
  assign release_req    = release_req_q;
  assign release_period = release_period_q;
  assign day_done       = day_done_q;
  assign release_ovf    = release_ovf_q;

endmodule
